// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the RV32 multi-cycle control unit:
// FSM state encoding, trap causes, branch fun3 codes and the default reset PC.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE          = 2'd0,
        CAUSE_ILLEGAL       = 2'd1,
        CAUSE_FETCH_TIMEOUT = 2'd2,
        CAUSE_MISALIGNED    = 2'd3
    } trap_cause_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/core_control_unit_branch_resolver.sv
// Combinational branch decision from the branch fun3 and the ALU compare result.
// Less-than compares arrive from the ALU as a 0/1 value in bit 0.
module branch_resolver
    import core_ctrl_pkg::*;
(
    input  logic [2:0]  branchT,
    input  logic [31:0] aluResult,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (branchT)
            F3_BEQ:  taken = (aluResult == '0);
            F3_BNE:  taken = (aluResult != '0);
            F3_BLT:  taken = aluResult[0];
            F3_BLTU: taken = aluResult[0];
            F3_BGE:  taken = ~aluResult[0];
            F3_BGEU: taken = ~aluResult[0];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/core_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with PC ownership and sticky traps.
// Define CORE_PERF_COUNTERS_EN to build the 64-bit cycle and retire counters.
module core_control_unit
    import core_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        haltReq,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic [31:0] instruction,
    input  logic        isVI,
    input  logic        isRT,
    input  logic        isIT,
    input  logic        isBT,
    input  logic        isJT,
    input  logic        isJump,
    input  logic        enRegWrite,
    input  logic [2:0]  branchT,
    input  logic [31:0] immediateValue,
    input  logic [31:0] rs1Data,
    input  logic [31:0] aluResult,
    output logic [31:0] pc,
    output logic        regWriteEn,
    output logic [31:0] regWriteData,
    output logic        instrRetired,
    output logic        trap,
    output logic [1:0]  trapCause,
    output logic [63:0] cycleCount,
    output logic [63:0] retireCount
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);

    state_t      state, next_state;
    trap_cause_t cause_q;

    logic [31:0] pc_q, instr_q, next_pc_q, alu_q, imm_q;
    logic [2:0]  branch_t_q;
    logic        is_bt_q, is_jt_q, is_jump_q, en_reg_write_q;
    logic [7:0]  timeout_cnt;
    logic        timeout_hit, taken, misaligned;
    logic [31:0] pc_plus4, rel_target, jalr_target, npc;
    logic        unused_flags;

    // Operand-type flags only matter to the ALU operand mux, not to sequencing.
    assign unused_flags = isRT ^ isIT;

    branch_resolver u_branch (
        .branchT   (branch_t_q),
        .aluResult (aluResult),
        .taken     (taken)
    );

    assign pc_plus4    = pc_q + 32'd4;
    assign rel_target  = pc_q + imm_q;
    assign jalr_target = (rs1Data + imm_q) & ~32'd1;
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

    always_comb begin
        npc = pc_plus4;
        if (is_jt_q)
            npc = rel_target;
        else if (is_jump_q)
            npc = jalr_target;
        else if (is_bt_q && taken)
            npc = rel_target;
    end

    assign misaligned = |npc[1:0];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:      if (!haltReq) next_state = ST_FETCH;
            ST_FETCH: begin
                if (imemRespValid)
                    next_state = ST_DECODE;
                else if (timeout_hit)
                    next_state = ST_TRAP;
            end
            ST_DECODE:    next_state = isVI ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE:   next_state = misaligned ? ST_TRAP : ST_WRITEBACK;
            ST_WRITEBACK: next_state = haltReq ? ST_IDLE : ST_FETCH;
            ST_TRAP:      next_state = ST_TRAP;
            default:      next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        imemReqValid = (state == ST_FETCH);
        regWriteEn   = (state == ST_WRITEBACK) && en_reg_write_q;
        instrRetired = (state == ST_WRITEBACK);
        trap         = (state == ST_TRAP);
        regWriteData = (is_jt_q || is_jump_q) ? pc_plus4 : alu_q;
    end

    assign imemReqAddr = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign trapCause   = cause_q;

    // Held at zero outside FETCH, so it is already clear on every FETCH entry.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            timeout_cnt <= '0;
        else if (state != ST_FETCH)
            timeout_cnt <= '0;
        else
            timeout_cnt <= timeout_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc_q           <= RESET_PC;
            instr_q        <= '0;
            next_pc_q      <= '0;
            alu_q          <= '0;
            imm_q          <= '0;
            branch_t_q     <= '0;
            is_bt_q        <= 1'b0;
            is_jt_q        <= 1'b0;
            is_jump_q      <= 1'b0;
            en_reg_write_q <= 1'b0;
            cause_q        <= CAUSE_NONE;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imemRespValid)
                        instr_q <= imemRespData;
                    else if (timeout_hit)
                        cause_q <= CAUSE_FETCH_TIMEOUT;
                end
                ST_DECODE: begin
                    if (isVI) begin
                        is_bt_q        <= isBT;
                        is_jt_q        <= isJT;
                        is_jump_q      <= isJump;
                        en_reg_write_q <= enRegWrite;
                        branch_t_q     <= branchT;
                        imm_q          <= immediateValue;
                    end else begin
                        cause_q <= CAUSE_ILLEGAL;
                    end
                end
                ST_EXECUTE: begin
                    alu_q     <= aluResult;
                    next_pc_q <= npc;
                    if (misaligned)
                        cause_q <= CAUSE_MISALIGNED;
                end
                ST_WRITEBACK: pc_q <= next_pc_q;
                default: ;
            endcase
        end
    end

`ifdef CORE_PERF_COUNTERS_EN
    logic [63:0] cycle_q, retire_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (state == ST_WRITEBACK)
                retire_q <= retire_q + 64'd1;
        end
    end

    assign cycleCount  = cycle_q;
    assign retireCount = retire_q;
`else
    assign cycleCount  = '0;
    assign retireCount = '0;
`endif

endmodule

// File: doc/core_control_unit.md
# core_control_unit

Multi-cycle sequencer for the RV32 integer core. It fetches each instruction over a valid/response handshake, holds it in an instruction register that feeds the instruction decoder, and steps the decoded instruction through execute and writeback. It also resolves branches and jumps, owns the PC, and raises sticky traps. It sits between instruction memory, the decoder, the ALU and the register file.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_TIMEOUT`, 255, maximum FETCH cycles without a response before a trap is raised (1..255).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rstN`  in  1  reset; asynchronous, active-low.
- `haltReq`  in  1  hold in IDLE; no new fetch starts while high.
- `imemReqValid`  out  1  fetch request.
- `imemReqAddr`  out  32  fetch address; equals `pc`.
- `imemRespValid`  in  1  fetch data valid.
- `imemRespData`  in  32  fetched instruction.
- `instruction`  out  32  instruction register; drives the decoder.
- `isVI`, `isRT`, `isIT`, `isBT`, `isJT`, `isJump`, `enRegWrite`  in  1 each  decoder flags.
- `branchT`  in  3  branch fun3.
- `immediateValue`  in  32  sign-extended immediate.
- `rs1Data`  in  32  register-file read port 1.
- `aluResult`  in  32  ALU output.
- `pc`  out  32  current PC.
- `regWriteEn`  out  1  one-cycle write strobe.
- `regWriteData`  out  32  write data.
- `instrRetired`  out  1  one-cycle retire pulse.
- `trap`  out  1  sticky trap flag.
- `trapCause`  out  2  trap cause: 0 none, 1 illegal instruction, 2 fetch timeout, 3 misaligned target.
- `cycleCount`, `retireCount`  out  64 each  performance counters.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
- **IDLE:** go to FETCH when `haltReq` is 0.
- **FETCH:** hold `imemReqValid` high. On `imemRespValid`, latch `imemRespData` into `instruction` and go to DECODE. `imemRespValid` is ignored in every other state.
- **Fetch timeout:** a counter clears on entry to FETCH. When it reaches `IMEM_TIMEOUT` with no response, go to TRAP with cause 2. If the response and the timeout land in the same cycle, the response wins.
- **DECODE:** if `isVI` is 0, go to TRAP with cause 1. Otherwise register the decoder flags, `branchT` and `immediateValue`.
- **EXECUTE:** sample `aluResult` and `rs1Data`, then compute the next PC:
  - JAL: `pc + imm`.
  - JALR (`isJump` high, `isJT` low): `(rs1Data + imm) & ~1`.
  - Branch taken: `pc + imm`.
  - Otherwise: `pc + 4`.
  - If bits [1:0] of the next PC are nonzero, go to TRAP with cause 3.
- **Branch condition** (on `aluResult`):
  - BEQ: result == 0.
  - BNE: result != 0.
  - BLT, BLTU: result[0] == 1.
  - BGE, BGEU: result[0] == 0.
  - Any other fun3: not taken.
- **WRITEBACK:**
  - `regWriteEn` = `enRegWrite`.
  - `regWriteData` = `pc + 4` for JAL/JALR, otherwise `aluResult`.
  - Update `pc`, pulse `instrRetired`.
  - Go to IDLE if `haltReq` is high, else FETCH.
- **rd = x0:** the strobe is still asserted; the register file discards the write.
- **TRAP:** absorbing. `trap` = 1 and `trapCause` holds its value until reset. `pc` holds the faulting PC.
- **Arithmetic:** all PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- **Reset values:** state IDLE, `pc` = `RESET_PC`, `instruction` = 0, all strobes 0, `trap` 0, `trapCause` 0, counters 0.
- Reset asserted mid-operation drops `imemReqValid` immediately.
- **Latency:** with a zero-wait memory (response in the first FETCH cycle), an instruction takes 4 cycles, FETCH through WRITEBACK. Each wait cycle adds one.
- The first request is asserted in the second cycle after reset deasserts.
- `regWriteEn` and `instrRetired` are high only during WRITEBACK. `pc` changes at the end of WRITEBACK.

## Configuration
- **With `CORE_PERF_COUNTERS_EN` defined:**
  - `cycleCount` increments every cycle outside reset, including in TRAP.
  - `retireCount` increments on `instrRetired`.
  - Both wrap at 2^64.
- **Without it:** both outputs are tied to 0 and no counter flops are built.

## Structure
- **Package `core_ctrl_pkg`:** FSM state encoding, trap cause constants, branch fun3 constants (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111), default `RESET_PC`.
- **Sub-module `branch_resolver`:** combinational. Takes `branchT` and `aluResult`, produces `taken`.

## Test plan
- **ADDI:** reset with zero-wait memory; fetch 0x00500093 (ADDI x1,x0,5) with `aluResult` 5. Expect `imemReqAddr` 0, a `regWriteEn` pulse with data 5 in cycle 4 of the instruction, then `pc` 4.
- **Branch:** fetch 0x00000463 (BEQ x0,x0,8) at pc 0. With `aluResult` 0, expect next `pc` 8 and no register write. Repeat with `aluResult` 1 and expect `pc` 4.
- **JAL:** JAL x1,16 at pc 0x10. Expect `regWriteData` 0x14 and `pc` 0x20.
- **JALR:** `rs1Data` 0x101, imm 0 → `pc` 0x100. `rs1Data` 0x102 → `trap` 1, cause 3, `pc` holds.
- **Illegal instruction:** fetch 0x00000003 (`isVI` = 0). Expect trap cause 1, no `regWriteEn`, `imemReqValid` stays 0 afterwards.
- **Timeout and halt:** with `IMEM_TIMEOUT` = 8 and no response, expect trap cause 2 after 8 FETCH cycles. Separately, holding `haltReq` high during WRITEBACK must park the block in IDLE; releasing it resumes fetch at the next `pc`.
